nes_controller_port: RTL and testbench
======================================

# nes_controller_port

Emulates NES standard controller port 1 ($4016) for the emulated CPU. Consumes the 8-bit USB HID keycode driven by the keycode PIO (written by the Nios II USB host software), decodes it into the eight NES button bits, and presents them through the NES strobe/serial-read protocol. It sits between the keycode PIO output and the CPU bus decoder's $4016 read/write path.

## Interface
Parameters:
- TURBO_DIV, 833_334, clk cycles per turbo phase toggle; 30 Hz toggle at 50 MHz. Used only with NES_CTRL_TURBO_EN.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- keycode  input  8  HID keycode from the keycode PIO; 0x00 means no key.
- strobe_we  input  1  one-cycle pulse on a CPU write to $4016.
- strobe_data  input  1  CPU write data bit 0, qualified by strobe_we.
- rd_en  input  1  high while the CPU reads $4016; may be multi-cycle.
- rd_data  output  1  serial button bit returned on D0 of the $4016 read.
- buttons  output  8  registered decoded button state for debug/LEDs; bit order {Right,Left,Down,Up,Start,Select,B,A}, A = bit 0.

## Operation
- Keymap, registered one cycle: 0x0E(K)→A, 0x0D(J)→B, 0x2B(Tab)→Select, 0x28(Enter)→Start, 0x1A(W)→Up, 0x16(S)→Down, 0x04(A)→Left, 0x07(D)→Right. Any other value gives buttons = 0x00. At most one bit is set.
- strobe_q: set to strobe_data on strobe_we.
- shift_q[7:0] behaviour:
  - While strobe_q = 1, or in the cycle a strobe_we write lands with strobe_data = 1, shift_q reloads with buttons every cycle.
  - With strobe_q = 0, shift_q holds except on a read edge.
- Read edge: rd_en & ~rd_en_q, where rd_en_q is rd_en registered. On a read edge with strobe_q = 0, shift right one place and fill bit 7 with 1.
  - After 8 edges rd_data reads 1 for every further read, matching official controllers.
  - Extra rd_en cycles after the edge do not shift.
- Read edge while strobe_q = 1: no shift. rd_data shows the live A bit.
- rd_data = shift_q[0], combinational from the register, so the CPU samples the current bit in the cycle it reads.
- Simultaneous strobe_we and read edge: the read returns the pre-write shift_q[0].
  - If the write sets strobe, the reload wins.
  - If the write clears strobe, the shift applies to the old contents.
- Reset: strobe_q = 0, shift_q = 0x00, buttons = 0x00, rd_en_q = 0, turbo state cleared. rd_data is therefore 0 out of reset.
- Reset asserted mid-sequence discards the partial shift. The next read after reset returns 0.

## Timing
- Keycode change → buttons: 1 cycle.
- Keycode change → reload into shift_q while strobed: 2 cycles.
- strobe_we with data 0 at edge N: shift_q frozen from edge N+1. The value loaded at edge N (from buttons) is the one read out.
- Read edge at cycle N: rd_data shows the next bit from cycle N+1.
- Sustained read rate: at most one shift per two cycles, because rd_en must drop for at least one cycle.

## Configuration
- NES_CTRL_TURBO_EN defined: 20-bit prescaler counts 0..TURBO_DIV-1. At wrap it toggles turbo_phase.
  - Keycode 0x0F(L) sets A = turbo_phase; 0x0B(H) sets B = turbo_phase.
  - Prescaler and phase reset to 0.
- NES_CTRL_TURBO_EN undefined: no prescaler or phase logic. 0x0F and 0x0B decode to 0x00.

## Structure
- Package nes_ctrl_pkg holds:
  - keycode localparams (KC_K, KC_J, KC_TAB, KC_ENTER, KC_W, KC_S, KC_A, KC_D, KC_L, KC_H);
  - button index constants BTN_A..BTN_RIGHT;
  - typedef nes_buttons_t (packed 8-bit).
- Sub-module nes_keymap: combinational keycode → nes_buttons_t decode, with a turbo_phase input used under NES_CTRL_TURBO_EN. Registering stays in the top.

## Test plan
- Reset then 10 read edges with no strobe → rd_data 0 for reads 1–8, then 1 for reads 9–10.
- keycode = 0x0E, write 1 then 0 to $4016, 8 reads → sequence 1,0,0,0,0,0,0,0, then 1s; buttons = 0x01.
- keycode = 0x07, full strobe/read cycle → bit 7 (eighth read) = 1, others 0. Change keycode to 0x1A mid-read with no strobe → remaining bits unchanged.
- Strobe held at 1, keycode toggles 0x0E/0x00, reads issued → rd_data tracks A with 2-cycle latency; no shifting.
- rd_en held high 5 cycles → exactly one shift. strobe_we (data 0) in the same cycle as a read edge → rd_data sampled = old bit 0; the shift applies to the old contents.
- NES_CTRL_TURBO_EN, TURBO_DIV = 4, keycode = 0x0F → buttons[0] toggles every 4 cycles. Without the macro → buttons = 0x00.

Source files
------------

// File: rtl/nes_ctrl_pkg.sv
// Shared keycode, button-index and type definitions for the NES controller port.
// NES_CTRL_TURBO_EN enables the turbo keycodes (KC_L, KC_H).
package nes_ctrl_pkg;

    localparam logic [7:0] KC_K     = 8'h0E;
    localparam logic [7:0] KC_J     = 8'h0D;
    localparam logic [7:0] KC_TAB   = 8'h2B;
    localparam logic [7:0] KC_ENTER = 8'h28;
    localparam logic [7:0] KC_W     = 8'h1A;
    localparam logic [7:0] KC_S     = 8'h16;
    localparam logic [7:0] KC_A     = 8'h04;
    localparam logic [7:0] KC_D     = 8'h07;
    localparam logic [7:0] KC_L     = 8'h0F;
    localparam logic [7:0] KC_H     = 8'h0B;

    localparam int unsigned BTN_A      = 0;
    localparam int unsigned BTN_B      = 1;
    localparam int unsigned BTN_SELECT = 2;
    localparam int unsigned BTN_START  = 3;
    localparam int unsigned BTN_UP     = 4;
    localparam int unsigned BTN_DOWN   = 5;
    localparam int unsigned BTN_LEFT   = 6;
    localparam int unsigned BTN_RIGHT  = 7;

    typedef logic [7:0] nes_buttons_t;

endpackage

// File: rtl/nes_keymap.sv
// Combinational HID keycode to NES button decode; at most one button set.
// Under NES_CTRL_TURBO_EN, L/H drive A/B from the turbo phase.
module nes_keymap
    import nes_ctrl_pkg::*;
(
    input  logic [7:0]   keycode_i,
    input  logic         turbo_phase_i,
    output nes_buttons_t buttons_o
);

    always_comb begin
        buttons_o = '0;
        case (keycode_i)
            KC_K:     buttons_o[BTN_A]      = 1'b1;
            KC_J:     buttons_o[BTN_B]      = 1'b1;
            KC_TAB:   buttons_o[BTN_SELECT] = 1'b1;
            KC_ENTER: buttons_o[BTN_START]  = 1'b1;
            KC_W:     buttons_o[BTN_UP]     = 1'b1;
            KC_S:     buttons_o[BTN_DOWN]   = 1'b1;
            KC_A:     buttons_o[BTN_LEFT]   = 1'b1;
            KC_D:     buttons_o[BTN_RIGHT]  = 1'b1;
`ifdef NES_CTRL_TURBO_EN
            KC_L:     buttons_o[BTN_A]      = turbo_phase_i;
            KC_H:     buttons_o[BTN_B]      = turbo_phase_i;
`endif
            default:  ;
        endcase
    end

`ifndef NES_CTRL_TURBO_EN
    logic unused_turbo_phase;
    assign unused_turbo_phase = turbo_phase_i;
`endif

endmodule

// File: rtl/nes_controller_port.sv
// NES controller port 1 ($4016): keycode decode, strobe latch and serial read-out.
// NES_CTRL_TURBO_EN adds a TURBO_DIV prescaler driving turbo A/B.
module nes_controller_port
    import nes_ctrl_pkg::*;
#(
    parameter int unsigned TURBO_DIV = 833_334
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] keycode,
    input  logic       strobe_we,
    input  logic       strobe_data,
    input  logic       rd_en,
    output logic       rd_data,
    output logic [7:0] buttons
);

    nes_buttons_t keymap_buttons;
    nes_buttons_t buttons_q;
    nes_buttons_t shift_q, shift_d;
    logic         strobe_q, strobe_d;
    logic         rd_en_q;
    logic         rd_edge;
    logic         turbo_phase;

    nes_keymap u_keymap (
        .keycode_i     (keycode),
        .turbo_phase_i (turbo_phase),
        .buttons_o     (keymap_buttons)
    );

    assign rd_edge = rd_en & ~rd_en_q;

    // A write that sets strobe reloads in the same cycle; a clearing write lets the
    // pending read edge shift the old contents.
    always_comb begin
        strobe_d = strobe_we ? strobe_data : strobe_q;
        shift_d  = shift_q;
        if (strobe_q || (strobe_we && strobe_data)) begin
            shift_d = buttons_q;
        end else if (rd_edge) begin
            shift_d = {1'b1, shift_q[7:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            strobe_q  <= 1'b0;
            shift_q   <= '0;
            buttons_q <= '0;
            rd_en_q   <= 1'b0;
        end else begin
            strobe_q  <= strobe_d;
            shift_q   <= shift_d;
            buttons_q <= keymap_buttons;
            rd_en_q   <= rd_en;
        end
    end

    assign rd_data = shift_q[0];
    assign buttons = buttons_q;

`ifdef NES_CTRL_TURBO_EN
    localparam logic [19:0] TurboLast = 20'(TURBO_DIV - 1);

    logic [19:0] prescaler_q;
    logic        turbo_phase_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prescaler_q   <= '0;
            turbo_phase_q <= 1'b0;
        end else if (prescaler_q == TurboLast) begin
            prescaler_q   <= '0;
            turbo_phase_q <= ~turbo_phase_q;
        end else begin
            prescaler_q   <= prescaler_q + 20'd1;
        end
    end

    assign turbo_phase = turbo_phase_q;
`else
    logic [19:0] unused_turbo_div;
    assign unused_turbo_div = 20'(TURBO_DIV);
    assign turbo_phase      = 1'b0;
`endif

endmodule

// File: tb/tb_nes_controller_port.sv
// Directed and randomized checks of the $4016 port against a latch-and-index model.
module tb_nes_controller_port;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] keycode;
    logic       strobe_we;
    logic       strobe_data;
    logic       rd_en;
    logic       rd_data;
    logic [7:0] buttons;

    int checks = 0;
    int errors = 0;

    // Model: strobed mode shows live A; on release the whole byte is latched and
    // successive reads index into it, returning 1 past the eighth.
    logic [7:0] key_model;
    logic [7:0] latched;
    int         idx;
    bit         strobed;

    nes_controller_port #(
        .TURBO_DIV (4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .keycode     (keycode),
        .strobe_we   (strobe_we),
        .strobe_data (strobe_data),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .buttons     (buttons)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_map(input logic [7:0] kc);
        logic [7:0] codes [8];
        codes = '{8'h0E, 8'h0D, 8'h2B, 8'h28, 8'h1A, 8'h16, 8'h04, 8'h07};
        for (int i = 0; i < 8; i++) begin
            if (kc == codes[i]) return 8'(1 << i);
        end
        return 8'h00;
    endfunction

    function automatic logic exp_rd();
        if (strobed) return key_model[0];
        if (idx < 8) return latched[idx];
        return 1'b1;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_key(input logic [7:0] kc);
        keycode   = kc;
        key_model = ref_map(kc);
        tick();
        tick();
    endtask

    task automatic strobe_write(input logic d);
        strobe_we   = 1'b1;
        strobe_data = d;
        tick();
        strobe_we   = 1'b0;
        strobe_data = 1'b0;
        if (d) begin
            strobed = 1'b1;
        end else if (strobed) begin
            strobed = 1'b0;
            latched = key_model;
            idx     = 0;
        end
    endtask

    task automatic do_read(input string tag, input int hold);
        rd_en = 1'b1;
        check(tag, {7'd0, rd_data}, {7'd0, exp_rd()});
        check({tag, "_btn"}, buttons, key_model);
        for (int i = 0; i < hold; i++) tick();
        rd_en = 1'b0;
        tick();
        if (!strobed) idx++;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        tick();
        tick();
        strobed = 1'b0;
        latched = 8'h00;
        idx     = 0;
        check("reset_btn", buttons, 8'h00);
        check("reset_rd", {7'd0, rd_data}, 8'h00);
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        logic [7:0] kc;
        logic [7:0] codes [8];
        logic       prev;
        int         n;
        bit         seen;
        codes       = '{8'h0E, 8'h0D, 8'h2B, 8'h28, 8'h1A, 8'h16, 8'h04, 8'h07};
        keycode     = 8'h00;
        key_model   = 8'h00;
        strobe_we   = 1'b0;
        strobe_data = 1'b0;
        rd_en       = 1'b0;
        apply_reset();

        // Ten reads with no strobe: eight zeros then ones.
        for (int i = 0; i < 10; i++) do_read($sformatf("nostrobe_rd%0d", i), 1);

        // A pressed: 1,0,...,0 then ones.
        set_key(8'h0E);
        strobe_write(1'b1);
        strobe_write(1'b0);
        check("keyA_btn", buttons, 8'h01);
        for (int i = 0; i < 10; i++) do_read($sformatf("keyA_rd%0d", i), 1);

        // Right pressed, key changes mid-read without strobe.
        set_key(8'h07);
        strobe_write(1'b1);
        strobe_write(1'b0);
        for (int i = 0; i < 3; i++) do_read($sformatf("keyD_rd%0d", i), 1);
        set_key(8'h1A);
        for (int i = 3; i < 9; i++) do_read($sformatf("keyD_rd%0d", i), 1);

        // Strobe held: rd_data follows A with two-cycle latency, reads do not shift.
        set_key(8'h00);
        strobe_write(1'b1);
        tick();
        keycode = 8'h0E;
        tick();
        check("live_lat1", {7'd0, rd_data}, 8'h00);
        tick();
        check("live_lat2", {7'd0, rd_data}, 8'h01);
        keycode = 8'h00;
        tick();
        check("live_hold1", {7'd0, rd_data}, 8'h01);
        tick();
        check("live_drop2", {7'd0, rd_data}, 8'h00);
        key_model = 8'h00;
        set_key(8'h0E);
        for (int i = 0; i < 3; i++) do_read($sformatf("live_rd%0d", i), 1);

        // Long rd_en gives exactly one shift each.
        set_key(8'h04);
        strobe_write(1'b0);
        for (int i = 0; i < 8; i++) do_read($sformatf("long_rd%0d", i), 5);

        // Clearing write coinciding with a read edge returns and shifts old contents.
        set_key(8'h0D);
        strobe_write(1'b1);
        strobe_write(1'b0);
        do_read("sim_rd0", 1);
        rd_en       = 1'b1;
        strobe_we   = 1'b1;
        strobe_data = 1'b0;
        check("sim_rd1", {7'd0, rd_data}, {7'd0, exp_rd()});
        tick();
        strobe_we = 1'b0;
        rd_en     = 1'b0;
        tick();
        idx++;
        for (int i = 2; i < 9; i++) do_read($sformatf("sim_rd%0d", i), 1);

        // Reset mid-sequence discards the partial shift.
        set_key(8'h0E);
        strobe_write(1'b1);
        strobe_write(1'b0);
        do_read("mid_rd0", 1);
        apply_reset();
        do_read("post_reset_rd", 1);

        // Randomized rounds.
        for (int r = 0; r < 24; r++) begin
            if ($urandom_range(0, 3) == 0) begin
                kc = 8'($urandom_range(0, 255));
                if (kc == 8'h0F || kc == 8'h0B) kc = 8'h00;
            end else begin
                kc = codes[$urandom_range(0, 7)];
            end
            set_key(kc);
            strobe_write(1'b1);
            strobe_write(1'b0);
            n = $urandom_range(3, 11);
            for (int i = 0; i < n; i++) begin
                if (i == 4 && $urandom_range(0, 1) == 1) set_key(codes[$urandom_range(0, 7)]);
                do_read($sformatf("rnd%0d_rd%0d", r, i), $urandom_range(1, 3));
            end
        end

`ifdef NES_CTRL_TURBO_EN
        // Turbo A toggles every four cycles.
        apply_reset();
        keycode   = 8'h0F;
        prev      = buttons[0];
        seen      = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (buttons[0] != prev) seen = 1'b1;
        end
        check("turbo_start", {7'd0, seen}, 8'h01);
        for (int k = 0; k < 3; k++) begin
            prev = buttons[0];
            for (int i = 1; i <= 4; i++) begin
                tick();
                check($sformatf("turbo_p%0d_c%0d", k, i), {7'd0, buttons[0]},
                      {7'd0, (i == 4) ? ~prev : prev});
            end
        end
        check("turbo_hi_bits", {1'b0, buttons[7:1]}, 8'h00);
        keycode = 8'h00;
`else
        // Turbo keycodes decode to nothing in the default build.
        prev = 1'b0;
        seen = 1'b0;
        keycode = 8'h0F;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("noturbo_L%0d", i), buttons, 8'h00);
        end
        keycode = 8'h0B;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("noturbo_H%0d", i), buttons, 8'h00);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
